// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: per-stage hold/flush bundle and the redirect FSM state.
package pipeline_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } redir_state_t;

    typedef struct packed {
        logic hold_f;
        logic hold_d;
        logic hold_e;
        logic hold_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

    function automatic logic any_hold(pipe_ctrl_t c);
        return c.hold_f | c.hold_d | c.hold_e | c.hold_m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/redirect bundle between the pipeline stages (master) and the hazard controller (slave).
interface pipeline_ctrl_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
);
    logic             imem_busy;
    logic             dmem_busy;
    logic             stopd;
    logic             branch;
    logic [PC_W-1:0]  branch_pc;
    logic             hold_f;
    logic             hold_d;
    logic             hold_e;
    logic             hold_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             kill_f;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output imem_busy, dmem_busy, stopd, branch, branch_pc,
        input  hold_f, hold_d, hold_e, hold_m, flush_d, flush_e, flush_w,
        input  kill_f, redirect_valid, redirect_pc, stall_cycles, flush_count
    );

    modport slave (
        input  imem_busy, dmem_busy, stopd, branch, branch_pc,
        output hold_f, hold_d, hold_e, hold_m, flush_d, flush_e, flush_w,
        output kill_f, redirect_valid, redirect_pc, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller: stall priority encoder, deferred-redirect FSM and perf counters.
// state | meaning
// IDLE  | no redirect outstanding; a taken branch redirects at once if fetch is idle
// PEND  | redirect waiting for the in-flight fetch; its response is killed
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    pipeline_ctrl_if.slave  bus
);

    redir_state_t     state_q, state_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    pipe_ctrl_t       ctrl;
    logic             br;
    logic             kill;
    logic             redir;
    logic [PC_W-1:0]  redir_pc;

    // Memory stall dominates; a taken branch squashes any load-use bubble on the wrong path.
    always_comb begin
        br   = bus.branch & ~bus.dmem_busy;
        ctrl = CTRL_NONE;
        if (bus.dmem_busy) begin
            ctrl.hold_f  = 1'b1;
            ctrl.hold_d  = 1'b1;
            ctrl.hold_e  = 1'b1;
            ctrl.hold_m  = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (bus.branch) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (bus.stopd) begin
            ctrl.hold_f  = 1'b1;
            ctrl.hold_d  = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        kill     = 1'b0;
        redir    = 1'b0;
        redir_pc = bus.branch_pc;
        case (state_q)
            IDLE: begin
                if (br) begin
                    if (bus.imem_busy) begin
                        tgt_d   = bus.branch_pc;
                        state_d = PEND;
                    end else begin
                        redir = 1'b1;
                    end
                end
            end
            PEND: begin
                kill     = 1'b1;
                redir_pc = tgt_q;
                if (br) begin
                    tgt_d = bus.branch_pc;
                end else if (!bus.imem_busy) begin
                    redir   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            if (any_hold(ctrl)) stall_q <= stall_q + 1'b1;
            if (redir)          flush_q <= flush_q + 1'b1;
        end
    end

    // All controls are forced low while reset is held, regardless of inputs.
    assign bus.hold_f         = resetn & ctrl.hold_f;
    assign bus.hold_d         = resetn & ctrl.hold_d;
    assign bus.hold_e         = resetn & ctrl.hold_e;
    assign bus.hold_m         = resetn & ctrl.hold_m;
    assign bus.flush_d        = resetn & ctrl.flush_d;
    assign bus.flush_e        = resetn & ctrl.flush_e;
    assign bus.flush_w        = resetn & ctrl.flush_w;
    assign bus.kill_f         = resetn & kill;
    assign bus.redirect_valid = resetn & redir;
    assign bus.redirect_pc    = resetn ? redir_pc : '0;
    assign bus.stall_cycles   = stall_q;
    assign bus.flush_count    = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: expected controls queued per stimulus cycle.
module tb_pipeline_ctrl;

    localparam logic [8:0] HF = 9'h100, HD = 9'h080, HE = 9'h040, HM = 9'h020;
    localparam logic [8:0] FD = 9'h010, FE = 9'h008, FW = 9'h004, KF = 9'h002, RV = 9'h001;
    localparam logic [8:0] MEM = HF | HD | HE | HM | FW;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [63:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_flush = '0;
    exp_t sb_q[$];

    pipeline_ctrl_if #(.PC_W(64), .CNT_W(32)) ifc ();

    pipeline_ctrl #(.PC_W(64), .CNT_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs_ctl();
        return {ifc.hold_f, ifc.hold_d, ifc.hold_e, ifc.hold_m, ifc.flush_d,
                ifc.flush_e, ifc.flush_w, ifc.kill_f, ifc.redirect_valid};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(string tag, bit dm, bit im, bit sd, bit br, logic [63:0] pc,
                        logic [8:0] ectl, logic [63:0] epc);
        exp_t e;
        @(negedge clk);
        ifc.dmem_busy = dm;
        ifc.imem_busy = im;
        ifc.stopd     = sd;
        ifc.branch    = br;
        ifc.branch_pc = pc;
        sb_q.push_back('{ctl: ectl, pc: epc});
        #1;
        chk({tag, ":stall_cnt"}, 64'(ifc.stall_cycles), 64'(exp_stall));
        chk({tag, ":flush_cnt"}, 64'(ifc.flush_count), 64'(exp_flush));
        e = sb_q.pop_front();
        chk({tag, ":ctl"}, 64'(obs_ctl()), 64'(e.ctl));
        if (e.ctl[0]) chk({tag, ":rpc"}, ifc.redirect_pc, e.pc);
        if (|e.ctl[8:5]) exp_stall++;
        if (e.ctl[0])    exp_flush++;
    endtask

    task automatic idle(string tag);
        step(tag, 0, 0, 0, 0, 64'h0, 9'h000, 64'h0);
    endtask

    initial begin
        ifc.dmem_busy = 1'b0;
        ifc.imem_busy = 1'b0;
        ifc.stopd     = 1'b0;
        ifc.branch    = 1'b1;
        ifc.branch_pc = 64'h1234;
        #2;
        chk("por:ctl", 64'(obs_ctl()), 64'h0);
        chk("por:rpc", ifc.redirect_pc, 64'h0);
        chk("por:stall", 64'(ifc.stall_cycles), 64'h0);
        @(negedge clk);
        ifc.branch = 1'b0;
        resetn = 1'b1;

        // branch with fetch idle: same-cycle redirect
        step("br_idle", 0, 0, 0, 1, 64'h8000_0040, FD | FE | RV, 64'h8000_0040);
        idle("after_br_idle");

        // branch with fetch busy: deferred until imem_busy drops
        step("brb_issue", 0, 1, 0, 1, 64'h8000_0100, FD | FE, 64'h0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("brb_wait%0d", i), 0, 1, 0, 0, 64'h0, KF, 64'h0);
        step("brb_redir", 0, 0, 0, 0, 64'h0, KF | RV, 64'h8000_0100);
        idle("after_brb");

        // memory stall masks branch and stopd
        step("mem1", 1, 0, 1, 1, 64'h8000_0200, MEM, 64'h0);
        for (int i = 2; i <= 5; i++)
            step($sformatf("mem%0d", i), 1, 0, 0, 1, 64'h8000_0200, MEM, 64'h0);
        step("mem_release", 0, 0, 0, 1, 64'h8000_0200, FD | FE | RV, 64'h8000_0200);
        idle("after_mem");

        // load-use bubble, then bubble overridden by a branch
        step("loaduse", 0, 0, 1, 0, 64'h0, HF | HD | FE, 64'h0);
        step("stopd_br", 0, 0, 1, 1, 64'h8000_0300, FD | FE | RV, 64'h8000_0300);

        // imem_busy alone causes nothing
        step("imem_only", 0, 1, 0, 0, 64'h0, 9'h000, 64'h0);

        // second branch while pending overwrites the target
        step("ow_issue", 0, 1, 0, 1, 64'h8000_0400, FD | FE, 64'h0);
        step("ow_again", 0, 1, 0, 1, 64'h8000_0500, KF | FD | FE, 64'h0);
        step("ow_redir", 0, 0, 0, 0, 64'h0, KF | RV, 64'h8000_0500);

        // memory stall while pending does not disturb the FSM
        step("pm_issue", 0, 1, 0, 1, 64'h8000_0600, FD | FE, 64'h0);
        step("pm_stall", 1, 1, 0, 0, 64'h0, KF | MEM, 64'h0);
        step("pm_redir", 0, 0, 0, 0, 64'h0, KF | RV, 64'h8000_0600);
        idle("after_pm");

        // reset asserted mid-PEND drops the redirect
        step("rp_issue", 0, 1, 0, 1, 64'h8000_0700, FD | FE, 64'h0);
        @(negedge clk);
        ifc.branch = 1'b1;
        ifc.imem_busy = 1'b0;
        ifc.dmem_busy = 1'b1;
        resetn = 1'b0;
        #1;
        chk("rst_pend:ctl", 64'(obs_ctl()), 64'h0);
        chk("rst_pend:rpc", ifc.redirect_pc, 64'h0);
        chk("rst_pend:stall", 64'(ifc.stall_cycles), 64'h0);
        chk("rst_pend:flush", 64'(ifc.flush_count), 64'h0);
        exp_stall = '0;
        exp_flush = '0;
        @(negedge clk);
        ifc.branch = 1'b0;
        ifc.dmem_busy = 1'b0;
        resetn = 1'b1;
        idle("post_rst");
        idle("post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
